// File: rtl/pipe_ctrl.sv
// Pipeline control: sequences PC redirects, pipeline flushes and holds, and
// buffers a redirect that arrives while the bus has the pipeline frozen.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_bus_i,
  output logic        pc_jump_en,
  output logic [31:0] pc_jump_addr,
  output logic        hold_pc,
  output logic        hold_ifid,
  output logic        hold_idex,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  ctrl_state,
  output logic [31:0] redirect_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD      = 2'd1,
    JUMP_PEND = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [2:0]  flush_cnt;
  logic        issue;
  logic        capture;
  logic        flush_dec;

  assign ctrl_state = state;

  // Next-state and output decode; bus hold always wins over flushing.
  always_comb begin
    next_state   = state;
    issue        = 1'b0;
    capture      = 1'b0;
    flush_dec    = 1'b0;
    pc_jump_en   = 1'b0;
    pc_jump_addr = RESET_PC;
    hold_pc      = 1'b0;
    hold_ifid    = 1'b0;
    hold_idex    = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;

    case (state)
      RUN, HOLD: begin
        if (hold_bus_i) begin
          hold_pc   = 1'b1;
          hold_ifid = 1'b1;
          hold_idex = 1'b1;
          if (jump_en_i) begin
            capture    = 1'b1;
            next_state = JUMP_PEND;
          end else begin
            next_state = HOLD;
          end
        end else if (hold_ex_i) begin
          // Execute result not final yet: any jump is dropped.
          hold_pc    = 1'b1;
          hold_ifid  = 1'b1;
          flush_idex = 1'b1;
          next_state = HOLD;
        end else if (jump_en_i) begin
          issue        = 1'b1;
          pc_jump_addr = jump_addr_i;
        end else begin
          next_state = RUN;
        end
      end
      JUMP_PEND: begin
        if (hold_bus_i) begin
          hold_pc   = 1'b1;
          hold_ifid = 1'b1;
          hold_idex = 1'b1;
        end else begin
          issue        = 1'b1;
          pc_jump_addr = pend_addr;
        end
      end
      FLUSH: begin
        if (hold_bus_i) begin
          hold_pc   = 1'b1;
          hold_ifid = 1'b1;
          hold_idex = 1'b1;
        end else begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          flush_dec  = 1'b1;
          if (flush_cnt <= 3'd1) begin
            next_state = RUN;
          end else begin
            next_state = FLUSH;
          end
        end
      end
      default: begin
        next_state = RUN;
      end
    endcase

    if (issue) begin
      pc_jump_en = 1'b1;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      next_state = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else begin
      pc_jump_en = 1'b0;
    end

    // Outputs are quiet while reset is held, whatever the inputs do.
    if (rst) begin
      pc_jump_en   = 1'b0;
      pc_jump_addr = RESET_PC;
      hold_pc      = 1'b0;
      hold_ifid    = 1'b0;
      hold_idex    = 1'b0;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
    end else begin
      hold_pc = hold_pc;
    end
  end

  // State, pending redirect, flush counter and redirect counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      pend_valid   <= 1'b0;
      pend_addr    <= 32'h0000_0000;
      flush_cnt    <= 3'd0;
      redirect_cnt <= 32'h0000_0000;
    end else begin
      state <= next_state;
      if (capture) begin
        pend_valid <= 1'b1;
        pend_addr  <= jump_addr_i;
      end else if (issue && (state == JUMP_PEND)) begin
        pend_valid <= 1'b0;
      end
      if (issue) begin
        flush_cnt    <= FLUSH_INIT;
        redirect_cnt <= redirect_cnt + 32'd1;
      end else if (flush_dec) begin
        flush_cnt <= flush_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; two instances (FLUSH_CYCLES=2 and 3) share stimulus.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_ex_i = 1'b0;
  logic        hold_bus_i = 1'b0;

  logic        a_jen, a_hpc, a_hifid, a_hidex, a_fifid, a_fidex;
  logic [31:0] a_jaddr, a_cnt;
  logic [1:0]  a_st;
  logic        b_jen, b_hpc, b_hifid, b_hidex, b_fifid, b_fidex;
  logic [31:0] b_jaddr, b_cnt;
  logic [1:0]  b_st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i),
    .pc_jump_en(a_jen), .pc_jump_addr(a_jaddr), .hold_pc(a_hpc), .hold_ifid(a_hifid),
    .hold_idex(a_hidex), .flush_ifid(a_fifid), .flush_idex(a_fidex),
    .ctrl_state(a_st), .redirect_cnt(a_cnt)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i),
    .pc_jump_en(b_jen), .pc_jump_addr(b_jaddr), .hold_pc(b_hpc), .hold_ifid(b_hifid),
    .hold_idex(b_hidex), .flush_ifid(b_fifid), .flush_idex(b_fidex),
    .ctrl_state(b_st), .redirect_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one cycle: inputs change at negedge, checks happen 1ns later
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_state", {30'd0, a_st}, 32'd0);
    chk("rst_jen", {31'd0, a_jen}, 32'd0);
    chk("rst_addr", a_jaddr, 32'h0);
    chk("rst_holds", {29'd0, a_hpc, a_hifid, a_hidex}, 32'd0);
    chk("rst_cnt", a_cnt, 32'd0);

    // reset in the middle of JUMP_PEND
    @(negedge clk);
    rst = 1'b0;
    hold_bus_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100;
    #1 chk("jp_cap_jen", {31'd0, a_jen}, 32'd0);
    step();
    jump_en_i = 1'b0;
    #1 chk("jp_state", {30'd0, a_st}, 32'd2);
    rst = 1'b1;
    #1 chk("jp_rst_state", {30'd0, a_st}, 32'd0);
    chk("jp_rst_jen", {31'd0, a_jen}, 32'd0);
    step();
    rst = 1'b0; hold_bus_i = 1'b0;
    #1 chk("jp_after_jen", {31'd0, a_jen}, 32'd0);
    step();
    chk("jp_after_jen2", {31'd0, a_jen}, 32'd0);
    step();
    chk("jp_after_cnt", a_cnt, 32'd0);
    chk("jp_after_cnt3", b_cnt, 32'd0);

    // plain jump in RUN
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0040;
    #1 chk("pj_jen", {31'd0, a_jen}, 32'd1);
    chk("pj_addr", a_jaddr, 32'h40);
    chk("pj_flush", {30'd0, a_fifid, a_fidex}, 32'd3);
    step();
    jump_en_i = 1'b0;
    #1 chk("pj_f1_state", {30'd0, a_st}, 32'd3);
    chk("pj_f1_flush", {30'd0, a_fifid, a_fidex}, 32'd3);
    chk("pj_f1_jen", {31'd0, a_jen}, 32'd0);
    chk("pj_cnt", a_cnt, 32'd1);
    step();
    chk("pj_run_state", {30'd0, a_st}, 32'd0);
    chk("pj_run_flush", {30'd0, a_fifid, a_fidex}, 32'd0);
    chk("pj_u3_still_flush", {30'd0, b_st}, 32'd3);
    step();
    chk("pj_u3_run", {30'd0, b_st}, 32'd0);

    // jump under bus hold, first captured address wins
    hold_bus_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h0000_0080;
    #1 chk("bh_c1_jen", {31'd0, a_jen}, 32'd0);
    chk("bh_c1_holds", {29'd0, a_hpc, a_hifid, a_hidex}, 32'd7);
    step();
    jump_addr_i = 32'h0000_0090;
    #1 chk("bh_c2_jen", {31'd0, a_jen}, 32'd0);
    chk("bh_c2_state", {30'd0, a_st}, 32'd2);
    step();
    jump_en_i = 1'b0;
    #1 chk("bh_c3_jen", {31'd0, a_jen}, 32'd0);
    chk("bh_c3_flush", {30'd0, a_fifid, a_fidex}, 32'd0);
    step();
    hold_bus_i = 1'b0;
    #1 chk("bh_rel_jen", {31'd0, a_jen}, 32'd1);
    chk("bh_rel_addr", a_jaddr, 32'h80);
    step();
    chk("bh_cnt", a_cnt, 32'd2);
    chk("bh_post_jen", {31'd0, a_jen}, 32'd0);
    step();
    step();
    chk("bh_u3_run", {30'd0, b_st}, 32'd0);

    // execute hold with a concurrent (ignored) jump
    hold_ex_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h0000_00C0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("ex_outs", {26'd0, a_hpc, a_hifid, a_fidex, a_hidex, a_jen, a_fifid}, 32'b111000);
      step();
    end
    hold_ex_i = 1'b0; jump_en_i = 1'b0;
    #1 chk("ex_state_hold", {30'd0, a_st}, 32'd1);
    chk("ex_rel_outs", {27'd0, a_hpc, a_hifid, a_hidex, a_fifid, a_fidex}, 32'd0);
    step();
    chk("ex_run", {30'd0, a_st}, 32'd0);
    chk("ex_cnt", a_cnt, 32'd2);

    // bus hold during FLUSH on the FLUSH_CYCLES=3 instance
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200;
    #1 chk("fh_issue", {31'd0, b_jen}, 32'd1);
    step();
    jump_en_i = 1'b0; hold_bus_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("fh_held_state", {30'd0, b_st}, 32'd3);
      chk("fh_held_outs", {27'd0, b_hpc, b_hifid, b_hidex, b_fifid, b_fidex}, 32'b11100);
      step();
    end
    hold_bus_i = 1'b0;
    #1 chk("fh_resume1", {27'd0, b_hpc, b_hifid, b_hidex, b_fifid, b_fidex}, 32'b00011);
    step();
    chk("fh_resume2", {27'd0, b_hpc, b_hifid, b_hidex, b_fifid, b_fidex}, 32'b00011);
    chk("fh_resume2_state", {30'd0, b_st}, 32'd3);
    step();
    chk("fh_done_state", {30'd0, b_st}, 32'd0);
    chk("fh_done_flush", {30'd0, b_fifid, b_fidex}, 32'd0);
    chk("fh_cnt3", b_cnt, 32'd3);
    chk("fh_u2_run", {30'd0, a_st}, 32'd0);

    // counter wrap
    force u2.redirect_cnt = 32'hFFFF_FFFF;
    step();
    release u2.redirect_cnt;
    #1 chk("wrap_pre", a_cnt, 32'hFFFF_FFFF);
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0300;
    step();
    jump_en_i = 1'b0;
    #1 chk("wrap_cnt", a_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit between the execute stage and the fetch/decode/execute pipeline registers. It takes branch/jump redirects and hold requests from execute and a stall from the memory bus. It sequences PC redirect, pipeline-register flushes and holds, and buffers a redirect that arrives while the pipeline is frozen. It also counts taken redirects for performance monitoring.

Parameters:
FLUSH_CYCLES, 2, cycles the flush outputs stay asserted after a redirect (range 1..7)
RESET_PC, 32'h0000_0000, address presented on pc_jump_addr while in reset (informational, not a jump)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
jump_en_i  input  1  redirect request from execute (jump_en2ctrl)
jump_addr_i  input  32  redirect target from execute (jump_addr2ctrl)
hold_ex_i  input  1  execute-stage multi-cycle hold (hold2ctrl)
hold_bus_i  input  1  memory/bus stall, freezes whole pipeline
pc_jump_en  output  1  load PC with pc_jump_addr this cycle
pc_jump_addr  output  32  redirect target
hold_pc  output  1  freeze PC
hold_ifid  output  1  freeze IF/ID register
hold_idex  output  1  freeze ID/EX register
flush_ifid  output  1  insert bubble into IF/ID
flush_idex  output  1  insert bubble into ID/EX
ctrl_state  output  2  current FSM state (debug)
redirect_cnt  output  32  number of redirects issued, wraps

Behaviour:
- Reset: the asynchronous rst forces state=RUN (2'd0), pend_valid=0, pend_addr=0, flush_cnt=0 and redirect_cnt=0. All control outputs are 0 and pc_jump_addr=RESET_PC. Reset mid-operation discards any pending redirect and any in-progress flush.
- States: RUN=0, HOLD=1, JUMP_PEND=2, FLUSH=3.
- Hold priority: hold_bus_i > flush > hold_ex_i.
  - hold_bus_i=1: hold_pc=hold_ifid=hold_idex=1, and no flush outputs are driven.
  - hold_ex_i=1 (bus idle): hold_pc=hold_ifid=1 and flush_idex=1, so a bubble enters ID/EX while execute works.
- Redirect issue:
  - Redirect outputs are combinational in the cycle of issue: pc_jump_en=1, pc_jump_addr=target, flush_ifid=flush_idex=1.
  - redirect_cnt increments at the next edge.
  - Next state is FLUSH with flush_cnt=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, next state is RUN.
- RUN:
  - jump_en_i=1 and no hold: issue a redirect from jump_addr_i. Latency is 0 cycles.
  - jump_en_i=1 and hold_bus_i=1: capture jump_addr_i into pend_addr, set pend_valid, go to JUMP_PEND. No pc_jump_en.
  - jump_en_i=1 and hold_ex_i=1: the jump is ignored, because the execute result is not final.
  - No jump and any hold: go to HOLD.
- HOLD: drive the hold outputs per priority.
  - Return to RUN when both holds are 0.
  - A jump arriving under a bus hold is handled exactly as in RUN (go to JUMP_PEND).
- JUMP_PEND:
  - While hold_bus_i=1: hold all stages. Repeated jump_en_i is ignored; the first captured address wins.
  - First cycle with hold_bus_i=0: issue the redirect from pend_addr and clear pend_valid.
  - hold_ex_i in this state is ignored, since the captured instruction is already resolved.
- FLUSH:
  - flush_ifid=flush_idex=1; flush_cnt decrements each cycle; go to RUN when it reaches 0.
  - jump_en_i is ignored, because it comes from a squashed instruction.
  - hold_bus_i=1 freezes flush_cnt and drives all holds with flushes deasserted. Flushing resumes after release.
- Arithmetic: redirect_cnt is 32-bit modulo and wraps from 32'hFFFF_FFFF to 0. Target addresses pass through unmodified; the block does no alignment check.
- ctrl_state and all FSM state are registered. All other outputs are combinational from state, registers and inputs.

Test Plan:
- Reset mid-JUMP_PEND: capture 32'h0000_0100 under bus hold, assert rst -> state=0, pc_jump_en=0; after release no redirect ever occurs and redirect_cnt=0.
- Plain jump in RUN: jump_en_i=1, jump_addr_i=32'h0000_0040 -> same cycle pc_jump_en=1, pc_jump_addr=32'h40, flush_ifid/idex=1. With FLUSH_CYCLES=2, flushes stay asserted 1 more cycle, then RUN; redirect_cnt=1.
- Jump under bus hold: hold_bus_i=1 for 3 cycles, jump_en_i=1 with addr 32'h80 then 32'h90 -> no pc_jump_en while held. On the release cycle, pc_jump_en=1 with addr 32'h80; exactly one redirect.
- Execute hold: hold_ex_i=1 for 4 cycles -> hold_pc=hold_ifid=1, flush_idex=1, hold_idex=0 each cycle. A concurrent jump_en_i is ignored (redirect_cnt unchanged).
- Bus hold during FLUSH (FLUSH_CYCLES=3): redirect, then hold_bus_i=1 for 2 cycles in FLUSH -> flushes drop to 0, holds=1. After release, flushes are asserted for the 2 remaining cycles.
- Counter wrap: preload redirect_cnt to 32'hFFFF_FFFF via force, issue one redirect -> redirect_cnt=0.
